sys_bus_initiator: RTL and testbench
====================================

// Module: sys_bus_initiator
// PURPOSE
//  Initiator end of the system bus (sys_addr/wdata/sel/wen/ren -> rdata/err/ack) served by housekeeping and other responders.
//  Accepts one command at a time over a valid/ready port and issues a single-cycle wen or ren strobe.
//  Waits for ack with a timeout, then returns rdata/err/timeout over a valid/ready response port.
//  Used by an internal sequencer or debug bridge to program responders without the processor.
// PARAMETERS
//  AW       32   bus address width
//  DW       32   bus data width; sel width is DW/8
//  TMO_CYC  255  max cycles from strobe to ack before timeout (1..2**TMO_W-1)
//  TMO_W    8    timeout counter width
// PORTS
//  clk_i        in   1      clock
//  rstn_i       in   1      reset, asynchronous, active low
//  cmd_valid_i  in   1      command present
//  cmd_ready_o  out  1      command accepted when valid&ready
//  cmd_we_i     in   1      1=write, 0=read
//  cmd_addr_i   in   AW     target address
//  cmd_wdata_i  in   DW     write data
//  cmd_sel_i    in   DW/8   byte select
//  rsp_valid_o  out  1      response present
//  rsp_ready_i  in   1      response consumed when valid&ready
//  rsp_rdata_o  out  DW     read data (0 for writes, errors, timeouts)
//  rsp_err_o    out  1      responder err or timeout
//  rsp_tmo_o    out  1      timeout occurred
//  sys_addr_o   out  AW     bus address
//  sys_wdata_o  out  DW     bus write data
//  sys_sel_o    out  DW/8   bus byte select
//  sys_wen_o    out  1      write strobe, one cycle
//  sys_ren_o    out  1      read strobe, one cycle
//  sys_rdata_i  in   DW     bus read data, valid with ack
//  sys_err_i    in   1      bus error, valid with ack
//  sys_ack_i    in   1      bus acknowledge
//  tmo_cnt_o    out  16     saturating count of timeouts
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; async assertion aborts any transfer immediately, no response is produced.
//  States: IDLE -> WAIT -> RESP -> IDLE. All outputs registered.
//  IDLE: cmd_ready_o=1. On accept, register addr/wdata/sel, set wen_o (we=1) or ren_o (we=0), clear timer, go to WAIT.
//  Strobe is high for exactly the first WAIT cycle; wen_o and ren_o are never high together.
//  sys_addr_o/wdata_o/sel_o stay stable from accept until the next accept.
//  WAIT: sample ack_i every edge, including the strobe cycle (0-latency responder legal).
//    On ack: rdata <= (read ? sys_rdata_i : 0), err <= sys_err_i, tmo <= 0; go to RESP.
//    Timer increments per WAIT cycle. With no ack at timer==TMO_CYC: rdata=0, err=1, tmo=1, tmo_cnt_o++ (saturate 0xFFFF); go to RESP.
//    If ack and timeout occur in the same cycle, ack wins.
//  RESP: rsp_valid_o=1; rsp_* held stable until rsp_ready_i. On handshake go to IDLE; cmd_ready_o is 1 the next cycle.
//  Latency: accept@E0, strobe in cycle after E0. With ack at E1, rsp_valid_o rises after E1.
//    Minimum issue interval is 3 cycles.
//  Ack in IDLE/RESP (late or stray) is ignored; it must not alter rsp_* or state.
//  cmd_ready_o=0 outside IDLE; cmd inputs are ignored there.
// STRUCTURE
//  Shared package sys_bus_pkg: SYS_AW=32, SYS_DW=32, SYS_SW=4, and an initiator state typedef (IDLE/WAIT/RESP).
//  Single module; the timer and FSM are small, so no sub-module is warranted.
// TESTING
//  Responder model: housekeeping-style, ack 1 cycle after strobe, with configurable latency/err.
//  1 Write 0x30 data 0xA5 sel 0xF -> one wen pulse with addr 0x30; rsp err=0, tmo=0, rdata=0; model LED reg == 0xA5.
//  2 Read 0x04, model returns 0xDEADBEEF at latency 1 -> one ren pulse; rsp_rdata_o=0xDEADBEEF, err=0; rsp_valid 2 cycles after accept.
//  3 Model never acks, TMO_CYC=255 -> rsp after 255 WAIT cycles with err=1, tmo=1, rdata=0; tmo_cnt_o=1.
//  4 rsp_ready_i low 5 cycles -> rsp_* stable, cmd_ready_o=0 throughout; second cmd accepted cycle after handshake.
//  5 Ack on the exact timeout cycle with err_i=1 -> tmo=0, err=1, tmo_cnt_o unchanged.
//  6 rstn_i low mid-WAIT, stray ack after reset -> all outputs 0 at once; no response; stray ack ignored in IDLE.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system bus initiator and its responders.
package sys_bus_pkg;

    localparam int SYS_AW = 32;
    localparam int SYS_DW = 32;
    localparam int SYS_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } init_state_e;

endpackage

// File: rtl/sys_bus_initiator.sv
// System bus initiator: takes one command over a valid/ready port, issues a
// single-cycle wen/ren strobe, waits for ack with a timeout, and returns the
// result over a valid/ready response port.
//
//  state | meaning
//  IDLE  | ready for a command (cmd_ready_o=1)
//  WAIT  | strobe issued, waiting for ack or timeout
//  RESP  | response presented until rsp_ready_i
module sys_bus_initiator
    import sys_bus_pkg::*;
#(
    parameter int AW      = SYS_AW,
    parameter int DW      = SYS_DW,
    parameter int TMO_CYC = 255,
    parameter int TMO_W   = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [DW-1:0]   cmd_wdata_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            rsp_tmo_o,
    output logic [AW-1:0]   sys_addr_o,
    output logic [DW-1:0]   sys_wdata_o,
    output logic [DW/8-1:0] sys_sel_o,
    output logic            sys_wen_o,
    output logic            sys_ren_o,
    input  logic [DW-1:0]   sys_rdata_i,
    input  logic            sys_err_i,
    input  logic            sys_ack_i,
    output logic [15:0]     tmo_cnt_o
);

    localparam int SW = DW / 8;
    // Timer holds the number of WAIT cycles already completed; the cycle in
    // which it reads TMO_CYC-1 is the last one an ack may arrive in.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    init_state_e       state, state_n;
    logic [TMO_W-1:0]  timer, timer_n;
    logic              is_read, is_read_n;
    logic              cmd_ready_n, rsp_valid_n, rsp_err_n, rsp_tmo_n;
    logic              wen_n, ren_n;
    logic [DW-1:0]     rsp_rdata_n, wdata_n;
    logic [AW-1:0]     addr_n;
    logic [SW-1:0]     sel_n;
    logic [15:0]       tmo_cnt_n;

    // Register every output and the FSM state; reset aborts any transfer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            timer       <= '0;
            is_read     <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            tmo_cnt_o   <= '0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            is_read     <= is_read_n;
            cmd_ready_o <= cmd_ready_n;
            rsp_valid_o <= rsp_valid_n;
            rsp_rdata_o <= rsp_rdata_n;
            rsp_err_o   <= rsp_err_n;
            rsp_tmo_o   <= rsp_tmo_n;
            sys_addr_o  <= addr_n;
            sys_wdata_o <= wdata_n;
            sys_sel_o   <= sel_n;
            sys_wen_o   <= wen_n;
            sys_ren_o   <= ren_n;
            tmo_cnt_o   <= tmo_cnt_n;
        end
    end

    // Next-state and next-output decode; strobes default low so they last one cycle.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        is_read_n   = is_read;
        cmd_ready_n = cmd_ready_o;
        rsp_valid_n = rsp_valid_o;
        rsp_rdata_n = rsp_rdata_o;
        rsp_err_n   = rsp_err_o;
        rsp_tmo_n   = rsp_tmo_o;
        addr_n      = sys_addr_o;
        wdata_n     = sys_wdata_o;
        sel_n       = sys_sel_o;
        wen_n       = 1'b0;
        ren_n       = 1'b0;
        tmo_cnt_n   = tmo_cnt_o;
        case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    addr_n      = cmd_addr_i;
                    wdata_n     = cmd_wdata_i;
                    sel_n       = cmd_sel_i;
                    wen_n       = cmd_we_i;
                    ren_n       = !cmd_we_i;
                    is_read_n   = !cmd_we_i;
                    timer_n     = '0;
                    cmd_ready_n = 1'b0;
                    state_n     = WAIT;
                end else begin
                    cmd_ready_n = 1'b1;
                end
            end
            WAIT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (sys_ack_i) begin
                    rsp_rdata_n = is_read ? sys_rdata_i : '0;
                    rsp_err_n   = sys_err_i;
                    rsp_tmo_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end else if (timer == TMO_LAST) begin
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    rsp_tmo_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                    if (tmo_cnt_o != 16'hFFFF) begin
                        tmo_cnt_n = tmo_cnt_o + 16'd1;
                    end
                    state_n     = RESP;
                end else begin
                    timer_n = timer + TMO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Self-checking bench for sys_bus_initiator with a housekeeping-style responder.
module tb_sys_bus_initiator;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_tmo_o;
    logic [31:0] sys_addr_o;
    logic [31:0] sys_wdata_o;
    logic [3:0]  sys_sel_o;
    logic        sys_wen_o;
    logic        sys_ren_o;
    logic [31:0] sys_rdata_i = '0;
    logic        sys_err_i = 1'b0;
    logic        sys_ack_i = 1'b0;
    logic [15:0] tmo_cnt_o;

    int checks = 0;
    int errors = 0;
    rsp_t exp_q[$];

    // responder model configuration and state
    int          lat_cfg = 1;
    logic        err_cfg = 1'b0;
    logic [31:0] rd_cfg = '0;
    int          pend_cnt = 0;
    bit          pending = 1'b0;
    bit          stray = 1'b0;
    logic [31:0] led_reg = '0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    bit          both_seen = 1'b0;

    sys_bus_initiator dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
        .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
        .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i),
        .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i), .tmo_cnt_o(tmo_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Responder: ack lat_cfg cycles after the strobe cycle (negative = never), plus stray acks.
    always @(negedge clk_i) begin
        sys_ack_i   = 1'b0;
        sys_err_i   = 1'b0;
        sys_rdata_i = '0;
        if (sys_wen_o) wen_cnt++;
        if (sys_ren_o) ren_cnt++;
        if (sys_wen_o && sys_ren_o) both_seen = 1'b1;
        if (!rstn_i) begin
            pending = 1'b0;
        end else begin
            if (sys_wen_o || sys_ren_o) begin
                pending  = (lat_cfg >= 0);
                pend_cnt = lat_cfg;
                if (sys_wen_o && sys_addr_o == 32'h30) led_reg = sys_wdata_o;
            end
            if (pending) begin
                if (pend_cnt == 0) begin
                    sys_ack_i   = 1'b1;
                    sys_err_i   = err_cfg;
                    sys_rdata_i = rd_cfg;
                    pending     = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (stray) begin
                sys_ack_i   = 1'b1;
                sys_err_i   = 1'b1;
                sys_rdata_i = 32'hFFFF_FFFF;
                stray       = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output time t_acc);
        int n = 0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_sel_i   = s;
        while (!cmd_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!cmd_ready_o) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_ready_o stayed %b, required 1", cmd_ready_o);
        end
        @(posedge clk_i);
        t_acc = $time;
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output time t_rise);
        int n = 0;
        while (!rsp_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (!rsp_valid_o) begin
            checks++;
            errors++;
            $display("FAIL rsp_wait: rsp_valid_o=%b after %0d cycles, required 1", rsp_valid_o, n);
        end
        t_rise = $time - 5;
    endtask

    task automatic handshake(output time t_hs);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        t_hs = $time;
        #1 rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({cmd_ready_o, rsp_valid_o, sys_wen_o, sys_ren_o, sys_addr_o, tmo_cnt_o, rsp_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b wen=%b ren=%b addr=%h tmo_cnt=%h, required all 0",
                     cmd_ready_o, rsp_valid_o, sys_wen_o, sys_ren_o, sys_addr_o, tmo_cnt_o);
        end
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: cmd_ready_o=%b, required 1", cmd_ready_o);
        end
    endtask

    task automatic test_write();
        time ta, tr, th;
        rsp_t e;
        int w0 = wen_cnt, r0 = ren_cnt;
        lat_cfg = 1; err_cfg = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b1, 32'h30, 32'hA5, 4'hF, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL write_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        checks++;
        if ((wen_cnt - w0) != 1 || (ren_cnt - r0) != 0) begin
            errors++;
            $display("FAIL write_strobe: wen pulses %0d ren pulses %0d, required 1 and 0", wen_cnt - w0, ren_cnt - r0);
        end
        checks++;
        if (sys_addr_o !== 32'h30 || sys_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL write_addr: addr %h sel %h, required 30 f", sys_addr_o, sys_sel_o);
        end
        checks++;
        if (led_reg !== 32'hA5) begin
            errors++;
            $display("FAIL write_led: led %h, required a5", led_reg);
        end
        checks++;
        if ((tr - ta) / 10 != 2) begin
            errors++;
            $display("FAIL write_latency: %0d cycles, required 2", (tr - ta) / 10);
        end
        handshake(th);
    endtask

    task automatic test_read();
        time ta, tr, th;
        rsp_t e;
        int w0 = wen_cnt, r0 = ren_cnt;
        lat_cfg = 1; err_cfg = 1'b0; rd_cfg = 32'hDEAD_BEEF;
        exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h04, 32'h0, 4'hF, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL read_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        checks++;
        if ((ren_cnt - r0) != 1 || (wen_cnt - w0) != 0) begin
            errors++;
            $display("FAIL read_strobe: ren pulses %0d wen pulses %0d, required 1 and 0", ren_cnt - r0, wen_cnt - w0);
        end
        checks++;
        if ((tr - ta) / 10 != 2) begin
            errors++;
            $display("FAIL read_latency: %0d cycles, required 2", (tr - ta) / 10);
        end
        handshake(th);
    endtask

    task automatic test_zero_latency();
        time ta, tr, th;
        rsp_t e;
        lat_cfg = 0; err_cfg = 1'b0; rd_cfg = 32'h0000_0055;
        exp_q.push_back('{rdata: 32'h55, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h10, 32'h0, 4'h1, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL zero_lat_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        checks++;
        if ((tr - ta) / 10 != 1) begin
            errors++;
            $display("FAIL zero_lat_latency: %0d cycles, required 1", (tr - ta) / 10);
        end
        handshake(th);
    endtask

    task automatic test_timeout();
        time ta, tr, th;
        rsp_t e;
        lat_cfg = -1; rd_cfg = 32'h1234_5678;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
        send_cmd(1'b0, 32'h08, 32'h0, 4'hF, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL timeout_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        checks++;
        if ((tr - ta) / 10 != 255) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles, required 255", (tr - ta) / 10);
        end
        checks++;
        if (tmo_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL timeout_count: tmo_cnt %0d, required 1", tmo_cnt_o);
        end
        handshake(th);
    endtask

    task automatic test_ack_at_timeout();
        time ta, tr, th;
        rsp_t e;
        lat_cfg = 254; err_cfg = 1'b1;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
        send_cmd(1'b1, 32'h20, 32'h77, 4'hF, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL ack_wins_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        checks++;
        if ((tr - ta) / 10 != 255 || tmo_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL ack_wins_timing: latency %0d tmo_cnt %0d, required 255 and 1", (tr - ta) / 10, tmo_cnt_o);
        end
        err_cfg = 1'b0;
        handshake(th);
    endtask

    task automatic test_back_to_back();
        time ta, tr, th, ta2;
        rsp_t e, snap;
        bit bad = 1'b0;
        lat_cfg = 1; err_cfg = 1'b0; rd_cfg = 32'h0BAD_F00D;
        exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h0C, 32'h0, 4'hF, ta);
        wait_valid(tr);
        snap = {rsp_rdata_o, rsp_err_o, rsp_tmo_o};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1 if (i == 1) stray = 1'b1;
            @(negedge clk_i);
            if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== snap || rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) bad = 1'b1;
        end
        e = exp_q.pop_front();
        checks++;
        if (snap !== e) begin
            errors++;
            $display("FAIL hold_rsp: got %h/%b/%b, required %h/%b/%b", snap.rdata, snap.err, snap.tmo, e.rdata, e.err, e.tmo);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable: rsp %h/%b/%b valid %b ready %b, required held with ready 0",
                     rsp_rdata_o, rsp_err_o, rsp_tmo_o, rsp_valid_o, cmd_ready_o);
        end
        handshake(th);
        rd_cfg = 32'h0000_C0DE;
        exp_q.push_back('{rdata: 32'hC0DE, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h14, 32'h0, 4'hF, ta2);
        checks++;
        if (ta2 - th != 10) begin
            errors++;
            $display("FAIL b2b_accept: accepted %0d ns after handshake, required 10", ta2 - th);
        end
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL b2b_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        handshake(th);
    endtask

    task automatic test_reset_abort();
        time ta, tr, th;
        rsp_t e;
        bit seen = 1'b0;
        lat_cfg = -1;
        send_cmd(1'b0, 32'h18, 32'h0, 4'hF, ta);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({cmd_ready_o, rsp_valid_o, sys_wen_o, sys_ren_o, sys_addr_o, tmo_cnt_o, rsp_err_o, rsp_tmo_o} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%b valid=%b addr=%h tmo_cnt=%h, required all 0",
                     cmd_ready_o, rsp_valid_o, sys_addr_o, tmo_cnt_o);
        end
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1 stray = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        checks++;
        if (seen || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_stray: rsp seen %b cmd_ready %b, required 0 and 1", seen, cmd_ready_o);
        end
        lat_cfg = 1; rd_cfg = 32'h600D_0001;
        exp_q.push_back('{rdata: 32'h600D_0001, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 32'h04, 32'h0, 4'hF, ta);
        wait_valid(tr);
        e = exp_q.pop_front();
        checks++;
        if ({rsp_rdata_o, rsp_err_o, rsp_tmo_o} !== e) begin
            errors++;
            $display("FAIL after_reset_rsp: got %h/%b/%b, required %h/%b/%b", rsp_rdata_o, rsp_err_o, rsp_tmo_o, e.rdata, e.err, e.tmo);
        end
        handshake(th);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero_latency();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0 || both_seen) begin
            errors++;
            $display("FAIL final_state: %0d responses outstanding, wen&ren overlap %b, required 0 and 0", exp_q.size(), both_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
